// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: master FSM state encoding and response codes.
package axi4_lite_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WR_ADDR_DATA = 3'd1;
  localparam logic [2:0] S_WR_RESP    = 3'd2;
  localparam logic [2:0] S_RD_ADDR    = 3'd3;
  localparam logic [2:0] S_RD_DATA    = 3'd4;
  localparam logic [2:0] S_RSP        = 3'd5;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  localparam logic [2:0] AXI_PROT_DEF = 3'b000;

endpackage

// File: rtl/axi4_lite_osc_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one
// AXI read or write and hands back the captured response.
module axi4_lite_osc_master
  import axi4_lite_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 5
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  input  logic                              i_cmd_valid,
  output logic                              o_cmd_ready,
  input  logic                              i_cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   i_cmd_wstrb,
  output logic                              o_rsp_valid,
  input  logic                              i_rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     o_rsp_rdata,
  output logic [1:0]                        o_rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  logic [2:0]    state_q, state_d;
  logic          rdy_q, rdy_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    resp_q, resp_d;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (i_cmd_valid && rdy_q) begin
          wr_d      = i_cmd_wr;
          addr_d    = i_cmd_addr;
          wdata_d   = i_cmd_wdata;
          wstrb_d   = i_cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = i_cmd_wr ? S_WR_ADDR_DATA
                               : S_RD_ADDR;
        end
      end
      (state_q == S_WR_ADDR_DATA): begin
        // AW and W retire independently; leave only once both have
        if (M_AXI_AWREADY) aw_done_d = 1'b1;
        if (M_AXI_WREADY)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)
          state_d = S_WR_RESP;
      end
      (state_q == S_WR_RESP): begin
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          rdata_d = '0;
          state_d = S_RSP;
        end
      end
      (state_q == S_RD_ADDR): begin
        if (M_AXI_ARREADY) state_d = S_RD_DATA;
      end
      (state_q == S_RD_DATA): begin
        if (M_AXI_RVALID) begin
          rdata_d = M_AXI_RDATA;
          resp_d  = M_AXI_RRESP;
          state_d = S_RSP;
        end
      end
      (state_q == S_RSP): begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is registered so it stays low until the first clock after reset
  assign rdy_d = (state_d == S_IDLE);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      rdy_q     <= rdy_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  assign o_cmd_ready   = rdy_q;
  assign o_rsp_valid   = (state_q == S_RSP);
  assign o_rsp_rdata   = wr_q ? '0 : rdata_q;
  assign o_rsp_resp    = resp_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = AXI_PROT_DEF;
  assign M_AXI_AWVALID = (state_q == S_WR_ADDR_DATA) && !aw_done_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = (state_q == S_WR_ADDR_DATA) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP);

  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = AXI_PROT_DEF;
  assign M_AXI_ARVALID = (state_q == S_RD_ADDR);
  assign M_AXI_RREADY  = (state_q == S_RD_DATA);

endmodule

// File: tb/tb_axi4_lite_osc_master.sv
// Bench for axi4_lite_osc_master: plays the AXI slave with a word memory
// and compares each response against a command-level memory model.
module tb_axi4_lite_osc_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rvalid, rready;

  int total = 0;
  int bad = 0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0;
  logic [4:0]  aw_cap, ar_cap;
  logic [31:0] wd_cap;
  logic [3:0]  ws_cap;
  logic [31:0] slv_mem [8];
  logic [31:0] ref_mem [8];
  logic [31:0] got;

  always #5 clk = ~clk;

  axi4_lite_osc_master #(
    .C_M_AXI_DATA_WIDTH(32),
    .C_M_AXI_ADDR_WIDTH(5)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_wr     (cmd_wr),
    .i_cmd_addr   (cmd_addr),
    .i_cmd_wdata  (cmd_wdata),
    .i_cmd_wstrb  (cmd_wstrb),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_resp   (rsp_resp),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWPROT (awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARPROT (arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  // Slave-side handshake monitor
  always @(posedge clk) begin
    if (awvalid && awready) begin
      aw_hs++;
      aw_cap = awaddr;
    end
    if (wvalid && wready) begin
      w_hs++;
      wd_cap = wdata;
      ws_cap = wstrb;
    end
    if (arvalid && arready) begin
      ar_hs++;
      ar_cap = araddr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  task automatic rsp_phase(input logic [31:0] ed, input logic [1:0] er,
                           input int rd, output logic [31:0] g);
    g = rsp_rdata;
    for (int i = 0; i <= rd; i++) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata", rsp_rdata, ed);
      chk("rsp_resp", 32'(rsp_resp), 32'(er));
      chk("cmd_rdy_busy", 32'(cmd_ready), 32'd0);
      if (i == rd) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("rsp_valid_off", 32'(rsp_valid), 32'd0);
    chk("cmd_rdy_back", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wr_txn(input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int awd, input int wd,
                        input int bd, input logic [1:0] br, input int rd,
                        input bit abort_rst);
    int aw0, w0, k;
    bit awdn, wdn;
    logic [31:0] g;
    wait_ready();
    aw0 = aw_hs;
    w0 = w_hs;
    cmd_valid = 1'b1; cmd_wr = 1'b1;
    cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
    chk("wr_cmd_rdy_lo", 32'(cmd_ready), 32'd0);
    awdn = 0; wdn = 0; k = 0;
    while (!(awdn && wdn)) begin
      chk("awvalid", 32'(awvalid), 32'(!awdn));
      chk("wvalid", 32'(wvalid), 32'(!wdn));
      chk("bready_early", 32'(bready), 32'd0);
      chk("awaddr", 32'(awaddr), 32'(a));
      chk("wdata", wdata, d);
      chk("wstrb", 32'(wstrb), 32'(s));
      chk("awprot", 32'(awprot), 32'd0);
      awready = (k >= awd);
      wready = (k >= wd);
      @(negedge clk);
      if (k >= awd) awdn = 1;
      if (k >= wd) wdn = 1;
      k++;
    end
    awready = 1'b0;
    wready = 1'b0;
    chk("aw_once", 32'(aw_hs - aw0), 32'd1);
    chk("w_once", 32'(w_hs - w0), 32'd1);
    slv_mem[aw_cap[4:2]] = merge(slv_mem[aw_cap[4:2]], wd_cap, ws_cap);
    ref_mem[a[4:2]] = merge(ref_mem[a[4:2]], d, s);
    chk("bready_on", 32'(bready), 32'd1);
    chk("aw_off", 32'(awvalid), 32'd0);
    chk("w_off", 32'(wvalid), 32'd0);
    if (abort_rst) begin
      rst_n = 1'b0;
      #1;
      chk("rst_awvalid", 32'(awvalid), 32'd0);
      chk("rst_wvalid", 32'(wvalid), 32'd0);
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_bready", 32'(bready), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_resp", 32'(rsp_resp), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_cmd_rdy_lo", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("rel_cmd_rdy_hi", 32'(cmd_ready), 32'd1);
      chk("rel_bready", 32'(bready), 32'd0);
    end else begin
      for (int i = 0; i < bd; i++) begin
        chk("bready_wait", 32'(bready), 32'd1);
        chk("rsp_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
      end
      bvalid = 1'b1;
      bresp = br;
      @(negedge clk);
      bvalid = 1'b0;
      bresp = 2'b00;
      chk("bready_off", 32'(bready), 32'd0);
      rsp_phase(32'd0, br, rd, g);
    end
  endtask

  task automatic rd_txn(input logic [4:0] a, input int ard, input int rdd,
                        input logic [1:0] rr, input int rd,
                        output logic [31:0] g);
    int ar0, k;
    bit dn;
    logic [31:0] ed;
    wait_ready();
    ar0 = ar_hs;
    ed = ref_mem[a[4:2]];
    cmd_valid = 1'b1; cmd_wr = 1'b0;
    cmd_addr = a; cmd_wdata = $urandom; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr = 5'($urandom);
    chk("rd_cmd_rdy_lo", 32'(cmd_ready), 32'd0);
    dn = 0; k = 0;
    while (!dn) begin
      chk("arvalid", 32'(arvalid), 32'd1);
      chk("araddr", 32'(araddr), 32'(a));
      chk("arprot", 32'(arprot), 32'd0);
      chk("rready_early", 32'(rready), 32'd0);
      arready = (k >= ard);
      @(negedge clk);
      if (k >= ard) dn = 1;
      k++;
    end
    arready = 1'b0;
    chk("ar_once", 32'(ar_hs - ar0), 32'd1);
    chk("arvalid_off", 32'(arvalid), 32'd0);
    for (int i = 0; i < rdd; i++) begin
      chk("rready_wait", 32'(rready), 32'd1);
      @(negedge clk);
    end
    chk("rready_on", 32'(rready), 32'd1);
    rvalid = 1'b1;
    rdata = slv_mem[ar_cap[4:2]];
    rresp = rr;
    @(negedge clk);
    rvalid = 1'b0;
    rdata = $urandom;
    rresp = 2'b01;
    chk("rready_off", 32'(rready), 32'd0);
    rsp_phase(ed, rr, rd, g);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    for (int i = 0; i < 8; i++) begin
      slv_mem[i] = '0;
      ref_mem[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_awvalid", 32'(awvalid), 32'd0);
    chk("reset_arvalid", 32'(arvalid), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_rdy_lo", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("first_rdy_hi", 32'(cmd_ready), 32'd1);

    // Simultaneous AW/W ready, OKAY
    wr_txn(5'h04, 32'h0000_0002, 4'hF, 0, 0, 0, 2'b00, 0, 0);
    // W ready three cycles ahead of AW
    wr_txn(5'h08, 32'hCAFE_F00D, 4'hF, 3, 0, 1, 2'b00, 0, 0);
    // AW ready ahead of W, partial strobes
    wr_txn(5'h08, 32'h1122_3344, 4'b0101, 0, 2, 0, 2'b00, 1, 0);
    rd_txn(5'h08, 0, 0, 2'b00, 0, got);
    chk("strobe_merge", got, 32'hCA22_F044);
    // Read 0x0C with ARREADY late
    wr_txn(5'h0C, 32'h0001_F3A5, 4'hF, 0, 0, 0, 2'b00, 0, 0);
    rd_txn(5'h0C, 2, 1, 2'b00, 0, got);
    chk("rd_0c_value", got, 32'h0001_F3A5);
    // SLVERR read held four cycles
    rd_txn(5'h04, 0, 0, 2'b10, 4, got);
    chk("rd_04_value", got, 32'h0000_0002);
    // SLVERR write passes through
    wr_txn(5'h10, 32'hDEAD_BEEF, 4'hF, 1, 1, 2, 2'b10, 2, 0);

    for (int i = 0; i < 24; i++) begin
      logic [4:0] a;
      logic [1:0] rsp;
      a = {3'($urandom_range(0, 7)), 2'b00};
      rsp = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
      if ($urandom_range(0, 1) == 1)
        wr_txn(a, $urandom, 4'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), rsp,
               $urandom_range(0, 3), 0);
      else
        rd_txn(a, $urandom_range(0, 3), $urandom_range(0, 3), rsp,
               $urandom_range(0, 3), got);
    end

    // Reset during WR_RESP, then confirm recovery
    wr_txn(5'h14, 32'h5A5A_A5A5, 4'hF, 1, 0, 0, 2'b00, 0, 1);
    rd_txn(5'h14, 1, 0, 2'b00, 0, got);
    chk("post_rst_rd", got, 32'h5A5A_A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
